// File: rtl/tqvp_sample_player_pkg.sv
// Shared constants for the sample player: register addresses, CTRL/STATUS
// bit positions and the playout state encoding.
package tqvp_sample_player_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_DIV_L  = 4'h1;
    localparam logic [3:0] ADDR_DIV_H  = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_OUT    = 4'h5;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_HOLD = 2;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_UNDERRUN = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_RUNNING  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tqvp_sample_fifo.sv
// Byte FIFO with first-word-fall-through read data; clr beats push and pop.
module tqvp_sample_fifo
    import tqvp_sample_player_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               do_push;
    logic               do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_W'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && (!full || do_pop) && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (!do_push && do_pop) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tqvp_sample_player.sv
// TinyQV byte peripheral: CPU pushes samples into a FIFO and they are played
// out on uo_out once every DIV+1 clocks while enabled.
module tqvp_sample_player
    import tqvp_sample_player_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        en_q, en_d;
    logic        hold_q, hold_d;
    logic        underrun_q, underrun_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  uo_q, uo_d;

    logic [7:0]         fifo_rdata;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_empty;
    logic               fifo_full;

    logic wr_data, wr_ctrl, wr_status, clr, tick, pop;
    logic underrun_set, overflow_set;
    logic unused_ui;

    assign unused_ui = ^ui_in;

    assign wr_data   = data_write && (address == ADDR_DATA);
    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign clr       = wr_ctrl && data_in[CTRL_CLR];

    // The rate counter only runs while in RUN with EN still set, so the
    // cycle that sees EN drop neither ticks nor pops.
    assign tick = (state_q == ST_RUN) && en_q && (cnt_q == 16'd0);
    assign pop  = tick && !fifo_empty && !clr;

    assign underrun_set = tick && !pop;
    assign overflow_set = wr_data && fifo_full && !pop && !clr;

    tqvp_sample_fifo #(
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_data),
        .pop   (pop),
        .clr   (clr),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = 16'd0;
        div_d      = div_q;
        en_d       = en_q;
        hold_d     = hold_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        uo_d       = uo_q;

        case (state_q)
            ST_IDLE: if (en_q)  state_d = ST_RUN;
            ST_RUN:  if (!en_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_RUN) && en_q) begin
            cnt_d = tick ? div_q : cnt_q - 16'd1;
        end

        if (pop)       uo_d = fifo_rdata;
        else if (tick) uo_d = hold_q ? uo_q : 8'h00;

        if (data_write && (address == ADDR_DIV_L)) div_d[7:0]  = data_in;
        if (data_write && (address == ADDR_DIV_H)) div_d[15:8] = data_in;
        if (wr_ctrl) begin
            en_d   = data_in[CTRL_EN];
            hold_d = data_in[CTRL_HOLD];
        end

        // Write-1-clear first so a same-cycle set takes priority.
        if (wr_status && data_in[STAT_UNDERRUN]) underrun_d = 1'b0;
        if (wr_status && data_in[STAT_OVERFLOW]) overflow_d = 1'b0;
        if (underrun_set) underrun_d = 1'b1;
        if (overflow_set) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            div_q      <= 16'd0;
            en_q       <= 1'b0;
            hold_q     <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            uo_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            en_q       <= en_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            uo_q       <= uo_d;
        end
    end

    assign uo_out = uo_q;

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_DATA:   data_out = 8'(fifo_level);
            ADDR_DIV_L:  data_out = div_q[7:0];
            ADDR_DIV_H:  data_out = div_q[15:8];
            ADDR_CTRL:   data_out = {5'b0, hold_q, 1'b0, en_q};
            ADDR_STATUS: data_out = {3'b0, (state_q == ST_RUN), overflow_q,
                                     underrun_q, fifo_full, fifo_empty};
            ADDR_OUT:    data_out = uo_q;
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_sample_player.sv
// Directed and randomized checks of the sample player against a queue-based
// model of its register behaviour.
module tb_tqvp_sample_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    tqvp_sample_player dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, rate counter as clocks remaining
    // until the next sample is due.
    logic [7:0]  mq[$];
    logic [15:0] m_div;
    bit          m_en, m_hold, m_under, m_over, m_run;
    int          m_cnt;
    logic [7:0]  m_out;

    function automatic void model_reset();
        mq.delete();
        m_div = 16'h0; m_en = 0; m_hold = 0; m_under = 0; m_over = 0;
        m_run = 0; m_cnt = 0; m_out = 8'h00;
    endfunction

    function automatic logic [7:0] model_read(logic [3:0] a);
        case (a)
            4'h0: return 8'(mq.size());
            4'h1: return m_div[7:0];
            4'h2: return m_div[15:8];
            4'h3: return {5'b0, m_hold, 1'b0, m_en};
            4'h4: return {3'b0, m_run, m_over, m_under, mq.size() == 8, mq.size() == 0};
            4'h5: return m_out;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_step(bit we, logic [3:0] a, logic [7:0] d);
        bit sample_due, clr, popped, accept, u_set, o_set;
        sample_due = m_run && m_en && (m_cnt == 0);
        clr        = we && a == 4'h3 && d[1];
        popped     = sample_due && mq.size() > 0 && !clr;
        u_set      = sample_due && !popped;
        accept     = we && a == 4'h0 && !clr && (mq.size() < 8 || popped);
        o_set      = we && a == 4'h0 && !clr && !accept;
        if (popped)          m_out = mq[0];
        else if (sample_due) m_out = m_hold ? m_out : 8'h00;
        if (clr) mq.delete();
        else begin
            if (popped) void'(mq.pop_front());
            if (accept) mq.push_back(d);
        end
        if (m_run && m_en) m_cnt = sample_due ? int'(m_div) : m_cnt - 1;
        else               m_cnt = 0;
        m_run = m_en;
        if (we && a == 4'h4 && d[2]) m_under = 0;
        if (we && a == 4'h4 && d[3]) m_over = 0;
        if (u_set) m_under = 1;
        if (o_set) m_over = 1;
        if (we && a == 4'h1) m_div[7:0] = d;
        if (we && a == 4'h2) m_div[15:8] = d;
        if (we && a == 4'h3) begin m_en = d[0]; m_hold = d[2]; end
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_step(data_write, address, data_in);
        @(posedge clk);
        #1;
        chk("uo_out", uo_out, m_out);
        chk("data_out", data_out, model_read(address));
    endtask

    task automatic wr(logic [3:0] a, logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        cyc();
        data_write = 1'b0;
    endtask

    task automatic idle(int n);
        data_write = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic rd(logic [3:0] a, string tag, logic [7:0] exp);
        address = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    logic [7:0] b [8];
    logic [7:0] extra;
    logic [7:0] exp_reset [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ui_in = 8'hA5; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        model_reset();
        exp_reset = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        #3;
        for (int i = 0; i < 6; i++) rd(4'(i), "reset_read", exp_reset[i]);
        chk("reset_uo", uo_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // Basic playout at DIV=3, then underrun with HOLD=0.
        wr(4'h1, 8'd3); wr(4'h2, 8'd0);
        wr(4'h0, 8'h10); wr(4'h0, 8'h20); wr(4'h0, 8'h30);
        wr(4'h3, 8'h01);
        idle(2); chk("play_first", uo_out, 8'h10);
        idle(3); chk("play_hold_gap", uo_out, 8'h10);
        idle(1); chk("play_second", uo_out, 8'h20);
        idle(4); chk("play_third", uo_out, 8'h30);
        idle(4); chk("underrun_zero", uo_out, 8'h00);
        rd(4'h4, "underrun_status", 8'h15);

        // Same again with HOLD=1: last sample persists.
        wr(4'h3, 8'h00); idle(2); wr(4'h4, 8'h04);
        rd(4'h4, "under_cleared", 8'h01);
        wr(4'h0, 8'h10); wr(4'h0, 8'h20); wr(4'h0, 8'h30);
        wr(4'h3, 8'h05);
        idle(14); chk("hold_last", uo_out, 8'h30);
        rd(4'h4, "hold_underrun", 8'h15);
        wr(4'h3, 8'h04); idle(2); wr(4'h4, 8'h04);
        rd(4'h4, "w1c_underrun", 8'h01);

        // Overflow: nine pushes into an eight-deep FIFO.
        wr(4'h1, 8'd0);
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom_range(1, 255));
            wr(4'h0, b[i]);
        end
        extra = 8'($urandom_range(1, 255));
        wr(4'h0, extra);
        rd(4'h0, "ovf_level", 8'd8);
        rd(4'h4, "ovf_status", 8'h0A);
        wr(4'h3, 8'h01);
        idle(2); chk("ovf_play0", uo_out, b[0]);
        for (int i = 1; i < 8; i++) begin
            idle(1); chk("ovf_play", uo_out, b[i]);
        end
        idle(1); chk("ovf_dropped", uo_out, 8'h00);
        wr(4'h3, 8'h00); idle(2); wr(4'h4, 8'h0C);

        // Push on a tick while full: both succeed.
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom_range(1, 255));
            wr(4'h0, b[i]);
        end
        extra = 8'($urandom_range(1, 255));
        wr(4'h3, 8'h01);
        idle(1);
        wr(4'h0, extra);
        chk("pp_level", data_out, 8'd8);
        chk("pp_uo", uo_out, b[0]);
        rd(4'h4, "pp_status", 8'h12);
        for (int i = 1; i < 8; i++) begin
            idle(1); chk("pp_play", uo_out, b[i]);
        end
        idle(1); chk("pp_last", uo_out, extra);
        wr(4'h3, 8'h00); idle(2); wr(4'h4, 8'h0C);

        // CLR on a full FIFO.
        for (int i = 0; i < 8; i++) wr(4'h0, 8'($urandom));
        wr(4'h3, 8'h02);
        chk("clr_reads_zero", data_out, 8'h00);
        rd(4'h0, "clr_level", 8'h00);
        rd(4'h4, "clr_status", 8'h01);

        // Reset mid-run.
        wr(4'h1, 8'd2); wr(4'h0, 8'h55); wr(4'h0, 8'h66);
        wr(4'h3, 8'h01);
        idle(4); chk("pre_reset_uo", uo_out, 8'h55);
        rst_n = 1'b0;
        #1;
        chk("async_reset_uo", uo_out, 8'h00);
        rd(4'h4, "async_reset_status", 8'h01);
        model_reset();
        rst_n = 1'b1;
        idle(3);
        rd(4'h0, "post_reset_level", 8'h00);

        // Randomized register traffic.
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3: wr(4'h0, 8'($urandom));
                4: wr(4'h1, 8'($urandom_range(0, 4)));
                5: wr(4'h2, ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00);
                6: wr(4'h3, {5'($urandom), 1'($urandom),
                             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)});
                7: wr(4'h4, 8'($urandom));
                8: wr(4'($urandom_range(6, 15)), 8'($urandom));
                default: begin
                    address = 4'($urandom);
                    idle(1);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
